johnson_phase_monitor: RTL and testbench
========================================

# johnson_phase_monitor

Consumes the 8-bit output of the Johnson counter, decodes each code to a 4-bit phase index and checks that the sequence advances by exactly one phase per clock. It flags illegal codes and sequence breaks, maintains a lock indication, and keeps a saturating error tally for status readout. The block sits directly downstream of `johnson_counter_8bit` and shares its clock domain.

## Interface
- `LOCK_CYCLES`, 16: number of consecutive correct +1 steps required to declare lock (1..255).
- `ERR_W`, 8: width of the saturating error counter.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset_n` input 1: asynchronous, active-low reset.
- `count` input 8: Johnson code from the counter, sampled every posedge.
- `clear` input 1: synchronous clear; zeroes `err_count` and returns the FSM to UNLOCKED.
- `phase` output 4: decoded phase index of the last legal sample.
- `phase_valid` output 1: the last sample was a legal Johnson code.
- `illegal` output 1: one-cycle pulse; the last sample was not a legal code.
- `seq_err` output 1: one-cycle pulse; a legal sample did not follow the previous phase by +1 while LOCKED.
- `locked` output 1: high while the FSM is in LOCKED.
- `err_count` output ERR_W: saturating count of `illegal` and `seq_err` pulses.

## Operation
- **Legal codes (16).**
  - Phase k for k=0..8: the top k bits are 1 and the rest are 0 (0→00000000, 1→10000000, …, 8→11111111).
  - Phase k for k=9..15: the top (k−8) bits are 0 and the rest are 1 (9→01111111, …, 15→00000001).
  - Any other value is illegal.
- **Reset values.** `phase`=0, `phase_valid`=0, `illegal`=0, `seq_err`=0, `locked`=0, `err_count`=0. FSM=UNLOCKED, run counter=0, previous-phase register=0.
- **FSM states: UNLOCKED, ACQUIRE, LOCKED.**
  - UNLOCKED:
    - Legal sample → ACQUIRE, anchor prev=phase, run=0.
    - Illegal sample → stay, pulse `illegal`.
  - ACQUIRE:
    - Legal sample with phase == (prev+1) mod 16 → run+1. When run reaches LOCK_CYCLES → LOCKED.
    - Legal sample but not +1 → stay, re-anchor, run=0, no error pulse.
    - Illegal sample → UNLOCKED, pulse `illegal`.
  - LOCKED:
    - Legal +1 sample → stay.
    - Legal sample but not +1 (hold or skip) → ACQUIRE, re-anchor, run=0, pulse `seq_err`.
    - Illegal sample → UNLOCKED, pulse `illegal`.
- **Wrap-around.** 15→0 is a valid +1 step (mod-16 arithmetic on 4 bits).
- **Previous-phase register.** Updated on every legal sample and left unchanged on illegal samples. `phase` holds its last legal value while `phase_valid`=0.
- **Error counter.**
  - `err_count` increments by 1 for each `illegal` or `seq_err` pulse.
  - It saturates at 2^ERR_W−1 and never wraps.
  - Only one pulse is possible per cycle.
- **Clear.**
  - `clear` forces FSM=UNLOCKED, run=0, `err_count`=0 on the next edge.
  - Clear beats a simultaneous error: the count ends at 0, but the `illegal`/`seq_err` pulse still reflects the sample.
  - `phase`/`phase_valid` still update from the sample.
- **Async reset mid-operation.** `reset_n` low immediately forces all reset values regardless of clock.

## Timing
- All outputs are registered: sample taken at edge N appears on the outputs after edge N and holds until edge N+1. Latency is 1 cycle.
- `illegal` and `seq_err` are high for exactly one cycle per offending sample. Back-to-back offending samples give continuous high.
- Lock timing: anchor sample at edge N, then LOCK_CYCLES correct steps at edges N+1..N+LOCK_CYCLES. `locked` rises after edge N+LOCK_CYCLES.
- `locked` falls after the edge that samples the offending code.
- No combinational path from `count` to any output.

## Test plan
1. **Reset, then counter free-running from 00000000, LOCK_CYCLES=16.**
   - `phase` tracks 0,1,…,15,0.
   - `phase_valid`=1 from the first sample.
   - `locked` rises after the 17th sampled code.
   - No `illegal`/`seq_err`; `err_count`=0.
2. **While locked, force `count`=10100000 for one cycle, then resume the legal sequence.**
   - One `illegal` pulse; `phase_valid`=0 for that cycle; `phase` holds its prior value.
   - `locked` drops; `err_count`=1.
   - Relock after 17 further legal samples.
3. **While locked at phase 5, hold counter reset (`count`=00000000) for 3 cycles, then release.**
   - A single `seq_err` pulse on the first 0 sample; `err_count` +1.
   - FSM goes to ACQUIRE; the held 0s re-anchor with no further errors.
   - Relock after 0,1,…,16 steps.
4. **Wrap check.** Present 14,15,0,1 codes (00000011, 00000001, 00000000, 10000000) while LOCKED → no `seq_err`, `locked` stays 1.
5. **Saturation and clear, ERR_W=2.**
   - Drive 5 illegal codes: `err_count` reaches 3 and holds.
   - Assert `clear` together with a 6th illegal code: `illegal` pulses and `err_count`=0.
6. **Async reset mid-LOCKED.** Deassert `reset_n` between edges → all outputs go to reset values immediately without a clock edge; FSM=UNLOCKED.

Source files
------------

// File: rtl/johnson_phase_monitor.sv
// Decodes 8-bit Johnson counter codes to a 4-bit phase. Checks that the phase advances
// by +1 every clock, and reports illegal codes, sequence breaks, lock state and a
// saturating error count.
module johnson_phase_monitor #(
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       count,
    input  logic             clear,
    output logic [3:0]       phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquire,
        StLocked
    } state_e;

    localparam logic [7:0] LockRun = 8'(LOCK_CYCLES);

    state_e           state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [3:0]       phase_q, phase_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic       code_legal;
    logic [3:0] code_phase;
    logic [3:0] next_phase;
    logic       step_ok;
    logic [7:0] run_inc;

    // Phases 0..8 fill ones from the MSB down; phases 9..15 then clear them from the MSB.
    function automatic logic [7:0] johnson_code(input int k);
        logic [7:0] c;
        c = '0;
        for (int j = 0; j < 8; j++) begin
            if (k <= 8) begin
                c[7-j] = (j < k);
            end else begin
                c[7-j] = (j >= k - 8);
            end
        end
        return c;
    endfunction

    always_comb begin
        code_legal = 1'b0;
        code_phase = '0;
        for (int k = 0; k < 16; k++) begin
            if (count == johnson_code(k)) begin
                code_legal = 1'b1;
                code_phase = 4'(k);
            end
        end
    end

    // The phase register doubles as the previous-phase anchor; 4-bit add wraps 15 -> 0.
    assign next_phase = phase_q + 4'd1;
    assign step_ok    = code_legal && (code_phase == next_phase);
    assign run_inc    = run_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        phase_d   = phase_q;
        valid_d   = code_legal;
        illegal_d = ~code_legal;
        seq_err_d = 1'b0;
        err_d     = err_q;

        if (code_legal) begin
            phase_d = code_phase;
        end

        unique case (state_q)
            StUnlocked: begin
                if (code_legal) begin
                    state_d = StAcquire;
                    run_d   = '0;
                end
            end
            StAcquire: begin
                if (!code_legal) begin
                    state_d = StUnlocked;
                    run_d   = '0;
                end else if (step_ok) begin
                    run_d = run_inc;
                    if (run_inc == LockRun) begin
                        state_d = StLocked;
                    end
                end else begin
                    run_d = '0;
                end
            end
            StLocked: begin
                if (!code_legal) begin
                    state_d = StUnlocked;
                    run_d   = '0;
                end else if (!step_ok) begin
                    state_d   = StAcquire;
                    run_d     = '0;
                    seq_err_d = 1'b1;
                end
            end
            default: begin
                state_d = StUnlocked;
                run_d   = '0;
            end
        endcase

        if ((illegal_d || seq_err_d) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end

        // Clear wins over a same-cycle error but leaves the pulses and phase untouched.
        if (clear) begin
            state_d = StUnlocked;
            run_d   = '0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StUnlocked;
            run_q     <= '0;
            phase_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == StLocked);
    assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed plus randomized bench for johnson_phase_monitor. It checks the DUT against a
// streak-counting reference model.
module tb_johnson_phase_monitor;

    localparam int LC      = 16;
    localparam int EW      = 2;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    count = '0;
    logic          clear = 1'b0;
    logic [3:0]    phase;
    logic          phase_valid;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [EW-1:0] err_count;

    johnson_phase_monitor #(
        .LOCK_CYCLES(LC),
        .ERR_W      (EW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .count      (count),
        .clear      (clear),
        .phase      (phase),
        .phase_valid(phase_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: anchor flag, +1 streak length, last legal phase.
    int m_prev, m_streak, m_err;
    bit m_have, m_valid, m_illegal, m_seq;

    function automatic logic [7:0] code_of(int k);
        int v;
        if (k <= 8) v = 255 ^ (255 >> k);
        else        v = 255 >> (k - 8);
        return v[7:0];
    endfunction

    task automatic model_reset();
        m_prev = 0; m_streak = 0; m_err = 0;
        m_have = 0; m_valid = 0; m_illegal = 0; m_seq = 0;
    endtask

    task automatic model_step(input logic [7:0] c, input bit clr);
        int ph;
        ph = -1;
        for (int k = 0; k < 16; k++) if (code_of(k) == c) ph = k;
        m_illegal = 0;
        m_seq     = 0;
        if (ph < 0) begin
            m_illegal = 1; m_valid = 0; m_have = 0; m_streak = 0;
        end else begin
            m_valid = 1;
            if (m_have && ph == (m_prev + 1) % 16) begin
                m_streak++;
            end else begin
                if (m_have && m_streak >= LC) m_seq = 1;
                m_streak = 0;
            end
            m_have = 1;
            m_prev = ph;
        end
        if ((m_illegal || m_seq) && m_err < ERR_MAX) m_err++;
        if (clr) begin
            m_have = 0; m_streak = 0; m_err = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".phase"}, 32'(phase), 32'(m_prev));
        chk({tag, ".valid"}, 32'(phase_valid), 32'(m_valid));
        chk({tag, ".illegal"}, 32'(illegal), 32'(m_illegal));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(m_seq));
        chk({tag, ".locked"}, 32'(locked), 32'(m_have && m_streak >= LC));
        chk({tag, ".err"}, 32'(err_count), 32'(m_err));
    endtask

    task automatic cycle(input logic [7:0] c, input bit clr, input string tag);
        count = c;
        clear = clr;
        @(posedge clk);
        #1;
        model_step(c, clr);
        check_model(tag);
    endtask

    initial begin
        int ph;
        int r;
        model_reset();
        #12;
        check_model("reset");
        reset_n = 1'b1;
        #1;

        // Free run from phase 0: lock after the 17th sample.
        for (int i = 0; i < 20; i++) begin
            cycle(code_of(i % 16), 1'b0, "free");
            if (i == 0)  chk("first_valid", 32'(phase_valid), 32'd1);
            if (i == 15) chk("not_locked16", 32'(locked), 32'd0);
            if (i == 16) chk("locked17", 32'(locked), 32'd1);
        end
        chk("free_err", 32'(err_count), 32'd0);

        // Illegal code while locked at phase 3.
        cycle(8'b1010_0000, 1'b0, "ill");
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(phase_valid), 32'd0);
        chk("ill_hold", 32'(phase), 32'd3);
        chk("ill_unlock", 32'(locked), 32'd0);
        chk("ill_err", 32'(err_count), 32'd1);
        for (int i = 0; i < 17; i++) begin
            cycle(code_of((4 + i) % 16), 1'b0, "relock1");
            if (i == 15) chk("relock1_early", 32'(locked), 32'd0);
        end
        chk("relock1", 32'(locked), 32'd1);

        // Locked at phase 5, then hold code 0 for three cycles.
        cycle(code_of(5), 1'b0, "p5");
        chk("p5_locked", 32'(locked), 32'd1);
        chk("p5_phase", 32'(phase), 32'd5);
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b0, "hold0");
            chk("hold_seq", 32'(seq_err), (i == 0) ? 32'd1 : 32'd0);
            chk("hold_err", 32'(err_count), 32'd2);
            chk("hold_lock", 32'(locked), 32'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            cycle(code_of(i % 16), 1'b0, "relock2");
            if (i == 15) chk("relock2_early", 32'(locked), 32'd0);
        end
        chk("relock2", 32'(locked), 32'd1);

        // Wrap 14, 15, 0, 1 while locked.
        for (int i = 1; i <= 13; i++) cycle(code_of(i), 1'b0, "towrap");
        for (int i = 14; i <= 17; i++) begin
            cycle(code_of(i % 16), 1'b0, "wrap");
            chk("wrap_seq", 32'(seq_err), 32'd0);
            chk("wrap_lock", 32'(locked), 32'd1);
        end

        // Saturation at 3 and clear against a simultaneous illegal code.
        for (int i = 0; i < 5; i++) begin
            cycle(8'b0101_0101, 1'b0, "sat");
            chk("sat_ill", 32'(illegal), 32'd1);
        end
        chk("sat_err", 32'(err_count), 32'd3);
        cycle(8'b1100_0001, 1'b1, "clr");
        chk("clr_ill", 32'(illegal), 32'd1);
        chk("clr_err", 32'(err_count), 32'd0);

        // Lock again, then reset asynchronously between edges.
        for (int i = 0; i < 18; i++) cycle(code_of((7 + i) % 16), 1'b0, "prereset");
        chk("prereset_lock", 32'(locked), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async");
        chk("async_lock", 32'(locked), 32'd0);
        #2 reset_n = 1'b1;

        // Randomized run: mostly +1 steps with holds, jumps, junk codes and clears.
        ph = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      ph = (ph + 1) % 16;
            else if (r < 90) ph = $urandom_range(0, 15);
            if (r >= 94) begin
                cycle(8'($urandom_range(0, 255)), ($urandom_range(0, 49) == 0), "rand");
            end else begin
                cycle(code_of(ph), ($urandom_range(0, 49) == 0), "rand");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, observed running expected done");
        $fatal(1);
    end

endmodule
